// File: rtl/elastic_fifo_sync_pkg.sv
// Shared constants and types for the RX elastic buffer.
package elastic_buffer_pkg;
    typedef logic [9:0] symbol_t;

    localparam symbol_t K28_5_RDN = 10'h0FA;
    localparam symbol_t K28_5_RDP = 10'h305;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_HIGH_WM    = 12;
    localparam int DEF_LOW_WM     = 4;
endpackage

// File: rtl/elastic_fifo_sync_if.sv
// Handshake, status and error bundle between the elastic buffer and its neighbours.
interface elastic_fifo_sync_if #(
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 4
);
    logic                   flush;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_en;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [ADDRESS_WIDTH:0] fill_level;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic                   skip_dropped;
    logic                   skip_inserted;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_valid, rd_data, fill_level, full, empty, almost_full, almost_empty,
               skip_dropped, skip_inserted, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_valid, rd_data, fill_level, full, empty, almost_full, almost_empty,
               skip_dropped, skip_inserted, overflow, underflow
    );
endinterface

// File: rtl/elastic_fifo_sync_ram.sv
// Symbol storage: one write port, one registered read port; the array itself is never cleared.
module elastic_ram_sync #(
    parameter int DATA_WIDTH    = 10,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is cleared; it holds between reads.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/elastic_fifo_sync.sv
// Single-clock elastic FIFO for the RX symbol path with SKIP drop/insert around the midpoint.
module elastic_fifo_sync
    import elastic_buffer_pkg::*;
#(
    parameter int                   DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                   DEPTH       = DEF_DEPTH,
    parameter int                   HIGH_WM     = DEF_HIGH_WM,
    parameter int                   LOW_WM      = DEF_LOW_WM,
    parameter logic [DATA_WIDTH-1:0] SKIP_SYMBOL = DATA_WIDTH'(K28_5_RDN),
    parameter bit                   SKIP_EN     = 1'b1
) (
    input  logic local_clock,
    input  logic local_reset,
    elastic_fifo_sync_if.slave bus
);
    localparam int ADDRESS_WIDTH = $clog2(DEPTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDRESS_WIDTH:0]   count;
    logic [DEPTH-1:0]         skip_tag;
    logic                     is_full, is_empty, is_af, is_ae, live, head_skip;
    logic                     do_replay, do_pop, do_insert, do_underflow;
    logic                     do_drop, do_push, do_overflow;
    logic                     rd_valid_q, sel_skip, dropped_q, inserted_q, overflow_q, underflow_q;
    logic [DATA_WIDTH-1:0]    ram_q;

    assign is_full  = (count == (ADDRESS_WIDTH+1)'(DEPTH));
    assign is_empty = (count == '0);
    assign is_af    = (count >= (ADDRESS_WIDTH+1)'(HIGH_WM));
    assign is_ae    = (count <  (ADDRESS_WIDTH+1)'(LOW_WM));
    assign live     = !local_reset && !bus.flush;
    // Per-entry SKIP tag lets the head be classified without a combinational RAM read.
    assign head_skip = skip_tag[rd_ptr];

    always_comb begin
        do_replay    = 1'b0;
        do_pop       = 1'b0;
        do_insert    = 1'b0;
        do_underflow = 1'b0;
        do_drop      = 1'b0;
        do_push      = 1'b0;
        do_overflow  = 1'b0;
        if (live && bus.rd_en) begin
            if (!is_empty && head_skip && SKIP_EN && is_ae) do_replay    = 1'b1;
            else if (!is_empty)                             do_pop       = 1'b1;
            else if (SKIP_EN)                               do_insert    = 1'b1;
            else                                            do_underflow = 1'b1;
        end
        if (live && bus.wr_en) begin
            if (SKIP_EN && bus.wr_data == SKIP_SYMBOL && is_af) do_drop     = 1'b1;
            else if (!is_full || do_pop)                        do_push     = 1'b1;
            else                                                do_overflow = 1'b1;
        end
    end

    always_ff @(posedge local_clock) begin
        if (do_push) skip_tag[wr_ptr] <= (bus.wr_data == SKIP_SYMBOL);
    end

    always_ff @(posedge local_clock) begin
        if (local_reset || bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid_q <= 1'b0;
            sel_skip   <= 1'b0;
            dropped_q  <= 1'b0;
            inserted_q <= 1'b0;
            if (local_reset) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count + (ADDRESS_WIDTH+1)'(do_push) - (ADDRESS_WIDTH+1)'(do_pop);
            rd_valid_q <= do_replay | do_pop | do_insert;
            if (do_replay | do_pop | do_insert) sel_skip <= do_insert;
            dropped_q   <= do_drop;
            inserted_q  <= do_replay | do_insert;
            overflow_q  <= overflow_q  | do_overflow;
            underflow_q <= underflow_q | do_underflow;
        end
    end

    elastic_ram_sync #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk   (local_clock),
        .rst   (local_reset | bus.flush),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (do_pop | do_replay),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = sel_skip ? SKIP_SYMBOL : ram_q;
    assign bus.fill_level    = count;
    assign bus.full          = is_full;
    assign bus.empty         = is_empty;
    assign bus.almost_full   = is_af;
    assign bus.almost_empty  = is_ae;
    assign bus.skip_dropped  = dropped_q;
    assign bus.skip_inserted = inserted_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule
